front_panel_ctrl: RTL and testbench
===================================

Name: front_panel_ctrl

Overview:
- Front-panel controller that turns rotary encoder events into a saturating volume setting, with step acceleration, mute toggling from a debounced push switch, and arbitration against host register writes.
- Acknowledges each encoder event to the encoder block via a read strobe.
- Applies volume and mute to the audio path only on audio_clk_enable boundaries.
- Gates the VU meter drive.

Parameters:
- VOL_MAX, 8'd200, upper saturation limit of volume.
- ACCEL_WINDOW, 24'd2_000_000, clk cycles; an event inside this window of the previous one uses ACCEL_STEP.
- ACCEL_STEP, 8'd4, step size when accelerated; otherwise the step is 1.
- DEBOUNCE_CYCLES, 20'd500_000, cycles the switch must be stable before a level is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- audio_clk_enable  in  1  96 kHz sample strobe, one clk wide.
- audio_enable  in  1  '1' while music is playing.
- enc_state_change  in  1  one-cycle pulse: encoder detent event.
- clkwise  in  1  direction, valid with enc_state_change; 1 = up.
- enc_switch  in  1  raw push switch, active-high, asynchronous to clk.
- host_wr_stb  in  1  one-cycle host write of volume.
- host_wr_data  in  8  host volume value.
- rotary_encoder_rd_stb  out  1  one-cycle acknowledge to the encoder.
- volume  out  8  applied volume, 0..VOL_MAX.
- mute  out  1  applied mute.
- vol_changed  out  1  one-cycle pulse when volume or mute is applied.
- vu_enable  out  1  audio_enable & ~mute, registered.
- status  out  8  {busy, pending, accel, mute_req, state[1:0], 2'b0}.

Behaviour:
- Reset (async, reset=0): volume=0, mute=1, rotary_encoder_rd_stb=0, vol_changed=0, vu_enable=0, all internal registers cleared, state=IDLE, accel timer saturated so the first event is never accelerated.
- Synchronizer: enc_switch passes through a 2-FF synchronizer.
- Debounce: a counter runs while the synchronized switch differs from the accepted level. The level is accepted when the counter reaches DEBOUNCE_CYCLES-1. Any bounce clears the counter.
- Mute toggle: each accepted 0->1 transition toggles mute_req. Releases do nothing.
- Pending flag: enc_state_change sets a one-deep pending register holding dir. An event arriving while pending is already set is dropped and is not acknowledged.
- State IDLE:
  - host_wr_stb -> HOST. Host wins if both requests occur in the same cycle; the encoder event stays pending.
  - Otherwise pending -> STEP.
- State HOST: vol_req = min(host_wr_data, VOL_MAX) -> IDLE. 1 cycle.
- State STEP:
  - step = (accel_timer < ACCEL_WINDOW) ? ACCEL_STEP : 1.
  - Up: vol_req = min(vol_req+step, VOL_MAX), computed 9-bit.
  - Down: vol_req = (vol_req < step) ? 0 : vol_req-step.
  - accel_timer cleared; it counts up and saturates.
  - -> ACK.
- State ACK: rotary_encoder_rd_stb=1 for exactly one cycle; pending cleared -> IDLE. Latency from enc_state_change in IDLE to rd_stb is 3 clk.
- A new enc_state_change in the same cycle pending clears re-sets pending.
- Apply stage: on audio_clk_enable, if {vol_req, mute_req} != {volume, mute}, then volume, mute <= requests and vol_changed pulses in the same cycle. Otherwise nothing changes.
- Boundaries:
  - Up at VOL_MAX and down at 0 saturate. Still acknowledged, no vol_changed.
  - Host values > VOL_MAX are clamped.
  - Reset mid-operation aborts to IDLE and drops pending.

Decomposition:
- Package front_panel_pkg holds:
  - typedef enum logic [1:0] {IDLE, HOST, STEP, ACK} fp_state_t.
  - Default constants VOL_MAX_DEF, ACCEL_STEP_DEF.
  - Function sat_add_sub(vol, step, up, max).
- Sub-module switch_debounce (synchronizer, counter, press pulse) is natural, parameterised by DEBOUNCE_CYCLES.

Test Plan (bench overrides ACCEL_WINDOW=100, DEBOUNCE_CYCLES=16):
- Reset release, then host write 8'd50 -> volume=50 at the next audio_clk_enable, vol_changed pulse, mute stays 1.
- Encoder events:
  - Three clkwise events spaced 500 clk from volume 50 -> volume 53; rd_stb 3 clk after each event.
  - Then two events spaced 20 clk -> 54 (first is not accelerated because its gap is >100), then 58.
- Host write 8'd250 -> volume 200. Clkwise event at 200 -> acknowledged, volume stays 200, no vol_changed. Counter-clockwise events from 2 with accel -> 1, then 0 (clamped).
- Switch press bouncing 5 toggles of <16 clk, then held 40 clk -> exactly one mute toggle 1->0. vu_enable follows audio_enable once the new mute state is applied.
- host_wr_stb and enc_state_change in the same cycle (vol 10, clkwise) -> HOST then STEP; final volume = host_wr_data+1 (or +ACCEL_STEP if within the window); one rd_stb.
- Event while pending is set -> dropped, single rd_stb. Assert reset during STEP -> volume=0, mute=1, no rd_stb after release.

Source files
------------

// File: rtl/front_panel_pkg.sv
// Shared types, default constants and volume arithmetic for the front-panel controller.
package front_panel_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, HOST = 2'd1, STEP = 2'd2, ACK = 2'd3} fp_state_t;

  localparam logic [7:0] VOL_MAX_DEF    = 8'd200;
  localparam logic [7:0] ACCEL_STEP_DEF = 8'd4;

  // Up saturates at max (9-bit sum so 255+step cannot wrap); down floors at zero.
  function automatic logic [7:0] sat_add_sub(input logic [7:0] vol, input logic [7:0] step,
                                             input logic up, input logic [7:0] max);
    logic [8:0] sum;
    sum = {1'b0, vol} + {1'b0, step};
    if (up) begin
      sat_add_sub = (sum > {1'b0, max}) ? max : sum[7:0];
    end else begin
      sat_add_sub = (vol < step) ? 8'd0 : vol - step;
    end
  endfunction

endpackage

// File: rtl/front_panel_ctrl_debounce.sv
// Push-switch conditioning: 2-FF synchronizer, stability counter, one-cycle press pulse.
module switch_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic press
);

  logic [1:0]  sync_reg;
  logic [19:0] cnt_reg;
  logic        level_reg;
  logic        press_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg  <= 2'b00;
      cnt_reg   <= 20'd0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], sw_raw};
      press_reg <= 1'b0;
      // Counter only runs while the input disagrees with the accepted level.
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= 20'd0;
      end else if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= 20'd0;
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 20'd1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/front_panel_ctrl.sv
// Front-panel volume/mute controller: encoder stepping with acceleration, host writes,
// mute toggle from the push switch, and sample-aligned application to the audio path.
module front_panel_ctrl
  import front_panel_pkg::*;
#(
  parameter logic [7:0]  VOL_MAX         = VOL_MAX_DEF,
  parameter logic [23:0] ACCEL_WINDOW    = 24'd2_000_000,
  parameter logic [7:0]  ACCEL_STEP      = ACCEL_STEP_DEF,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       audio_clk_enable,
  input  logic       audio_enable,
  input  logic       enc_state_change,
  input  logic       clkwise,
  input  logic       enc_switch,
  input  logic       host_wr_stb,
  input  logic [7:0] host_wr_data,
  output logic       rotary_encoder_rd_stb,
  output logic [7:0] volume,
  output logic       mute,
  output logic       vol_changed,
  output logic       vu_enable,
  output logic [7:0] status
);

  localparam logic [1:0]  ST_IDLE   = IDLE;
  localparam logic [1:0]  ST_HOST   = HOST;
  localparam logic [1:0]  ST_STEP   = STEP;
  localparam logic [1:0]  ST_ACK    = ACK;
  localparam logic [23:0] TIMER_SAT = 24'hFF_FFFF;

  logic [1:0]  state_reg;
  logic        pending_reg;
  logic        pending_dir_reg;
  logic [7:0]  host_data_reg;
  logic [7:0]  vol_req_reg;
  logic        mute_req_reg;
  logic [23:0] accel_timer_reg;
  logic        rd_stb_reg;
  logic [7:0]  volume_reg;
  logic        mute_reg;
  logic        vol_changed_reg;
  logic        vu_enable_reg;
  logic        sw_press;
  logic        accel_active;
  logic [7:0]  step;
  logic        ack_clear;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (enc_switch),
    .press  (sw_press)
  );

  assign accel_active = accel_timer_reg < ACCEL_WINDOW;
  assign step         = accel_active ? ACCEL_STEP : 8'd1;
  assign ack_clear    = (state_reg == ST_ACK);

  // One-deep event buffer; an event landing on the clearing cycle is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg     <= 1'b0;
      pending_dir_reg <= 1'b0;
    end else if (enc_state_change && (!pending_reg || ack_clear)) begin
      pending_reg     <= 1'b1;
      pending_dir_reg <= clkwise;
    end else if (ack_clear) begin
      pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      host_data_reg <= 8'd0;
      vol_req_reg   <= 8'd0;
      rd_stb_reg    <= 1'b0;
    end else begin
      rd_stb_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (host_wr_stb) begin
            host_data_reg <= host_wr_data;
            state_reg     <= ST_HOST;
          end else if (pending_reg) begin
            state_reg <= ST_STEP;
          end
        end
        ST_HOST: begin
          vol_req_reg <= (host_data_reg > VOL_MAX) ? VOL_MAX : host_data_reg;
          state_reg   <= ST_IDLE;
        end
        ST_STEP: begin
          vol_req_reg <= sat_add_sub(vol_req_reg, step, pending_dir_reg, VOL_MAX);
          state_reg   <= ST_ACK;
        end
        ST_ACK: begin
          rd_stb_reg <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Starts saturated so the first event after reset always takes the unit step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accel_timer_reg <= TIMER_SAT;
    end else if (state_reg == ST_STEP) begin
      accel_timer_reg <= 24'd0;
    end else if (accel_timer_reg != TIMER_SAT) begin
      accel_timer_reg <= accel_timer_reg + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mute_req_reg <= 1'b1;
    end else if (sw_press) begin
      mute_req_reg <= ~mute_req_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      volume_reg      <= 8'd0;
      mute_reg        <= 1'b1;
      vol_changed_reg <= 1'b0;
      vu_enable_reg   <= 1'b0;
    end else begin
      vol_changed_reg <= 1'b0;
      vu_enable_reg   <= audio_enable & ~mute_reg;
      if (audio_clk_enable && ({vol_req_reg, mute_req_reg} != {volume_reg, mute_reg})) begin
        volume_reg      <= vol_req_reg;
        mute_reg        <= mute_req_reg;
        vol_changed_reg <= 1'b1;
      end
    end
  end

  assign rotary_encoder_rd_stb = rd_stb_reg;
  assign volume                = volume_reg;
  assign mute                  = mute_reg;
  assign vol_changed           = vol_changed_reg;
  assign vu_enable             = vu_enable_reg;
  assign status = {(state_reg != ST_IDLE), pending_reg, accel_active, mute_req_reg, state_reg, 2'b00};

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Directed bench for front_panel_ctrl: vector table for host/encoder traffic plus
// hand sequences for debounce, arbitration, pending drop and reset abort.
module tb_front_panel_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       audio_clk_enable = 1'b0;
  logic       audio_enable;
  logic       enc_state_change;
  logic       clkwise;
  logic       enc_switch;
  logic       host_wr_stb;
  logic [7:0] host_wr_data;
  logic       rotary_encoder_rd_stb;
  logic [7:0] volume;
  logic       mute;
  logic       vol_changed;
  logic       vu_enable;
  logic [7:0] status;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int vc_cnt = 0;
  int ace_cnt = 0;

  front_panel_ctrl #(
    .ACCEL_WINDOW    (24'd100),
    .DEBOUNCE_CYCLES (20'd16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .audio_clk_enable      (audio_clk_enable),
    .audio_enable          (audio_enable),
    .enc_state_change      (enc_state_change),
    .clkwise               (clkwise),
    .enc_switch            (enc_switch),
    .host_wr_stb           (host_wr_stb),
    .host_wr_data          (host_wr_data),
    .rotary_encoder_rd_stb (rotary_encoder_rd_stb),
    .volume                (volume),
    .mute                  (mute),
    .vol_changed           (vol_changed),
    .vu_enable             (vu_enable),
    .status                (status)
  );

  always #5 clk = ~clk;

  // Sample strobe every 8 clocks.
  always @(negedge clk) begin
    ace_cnt = ace_cnt + 1;
    audio_clk_enable = ((ace_cnt % 8) == 0);
  end

  always @(negedge clk) begin
    if (rotary_encoder_rd_stb) rd_cnt = rd_cnt + 1;
    if (vol_changed) vc_cnt = vc_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enc_pulse(input logic up);
    enc_state_change = 1'b1;
    clkwise = up;
    @(negedge clk);
    enc_state_change = 1'b0;
  endtask

  // Cycles from the sampling edge of the event to the edge that raises rd_stb.
  task automatic wait_ack(output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (rotary_encoder_rd_stb) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    bit         is_host;
    logic [7:0] data;
    bit         up;
    int         gap;
    logic [7:0] exp_vol;
    int         exp_vc;
    int         exp_ack;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int vc0, rd0, lat;
    vecs[0]  = '{1'b1, 8'd50,  1'b0, 10,  8'd50,  1, 0};
    vecs[1]  = '{1'b0, 8'd0,   1'b1, 484, 8'd51,  1, 1};
    vecs[2]  = '{1'b0, 8'd0,   1'b1, 484, 8'd52,  1, 1};
    vecs[3]  = '{1'b0, 8'd0,   1'b1, 484, 8'd53,  1, 1};
    vecs[4]  = '{1'b0, 8'd0,   1'b1, 484, 8'd54,  1, 1};
    vecs[5]  = '{1'b0, 8'd0,   1'b1, 4,   8'd58,  1, 1};
    vecs[6]  = '{1'b1, 8'd250, 1'b0, 10,  8'd200, 1, 0};
    vecs[7]  = '{1'b0, 8'd0,   1'b1, 4,   8'd200, 0, 1};
    vecs[8]  = '{1'b1, 8'd2,   1'b0, 10,  8'd2,   1, 0};
    vecs[9]  = '{1'b0, 8'd0,   1'b0, 484, 8'd1,   1, 1};
    vecs[10] = '{1'b0, 8'd0,   1'b0, 4,   8'd0,   1, 1};

    reset = 1'b0;
    audio_enable = 1'b1;
    enc_state_change = 1'b0;
    clkwise = 1'b0;
    enc_switch = 1'b0;
    host_wr_stb = 1'b0;
    host_wr_data = 8'd0;
    idle(5);
    check("reset_volume", volume, 8'd0);
    check("reset_mute", mute, 1'b1);
    check("reset_rd_stb", rotary_encoder_rd_stb, 1'b0);
    check("reset_vol_changed", vol_changed, 1'b0);
    check("reset_vu_enable", vu_enable, 1'b0);
    reset = 1'b1;
    idle(20);
    check("idle_status", status, 8'h10);
    check("idle_vc_count", vc_cnt, 0);
    check("muted_vu_enable", vu_enable, 1'b0);

    for (int i = 0; i < 11; i++) begin
      idle(vecs[i].gap);
      vc0 = vc_cnt;
      rd0 = rd_cnt;
      if (vecs[i].is_host) begin
        host_wr_stb = 1'b1;
        host_wr_data = vecs[i].data;
        @(negedge clk);
        host_wr_stb = 1'b0;
      end else begin
        enc_pulse(vecs[i].up);
        wait_ack(lat);
        check($sformatf("vec%0d_ack_latency", i), lat, 3);
      end
      idle(16);
      check($sformatf("vec%0d_volume", i), volume, vecs[i].exp_vol);
      check($sformatf("vec%0d_vol_changed", i), vc_cnt - vc0, vecs[i].exp_vc);
      check($sformatf("vec%0d_rd_stb", i), rd_cnt - rd0, vecs[i].exp_ack);
      check($sformatf("vec%0d_mute", i), mute, 1'b1);
      $display("vec %0d host=%0d data=%0d up=%0d volume=%0d", i, vecs[i].is_host,
               vecs[i].data, vecs[i].up, volume);
    end

    // Bouncy press: short glitches must be ignored, the long hold toggles mute once.
    vc0 = vc_cnt;
    enc_switch = 1'b1; idle(6);
    enc_switch = 1'b0; idle(5);
    enc_switch = 1'b1; idle(7);
    enc_switch = 1'b0; idle(4);
    enc_switch = 1'b1; idle(40);
    idle(16);
    check("press_mute", mute, 1'b0);
    check("press_vol_changed", vc_cnt - vc0, 1);
    check("press_mute_req", status[4], 1'b0);
    check("press_vu_enable", vu_enable, 1'b1);
    $display("switch press: mute=%0d vu_enable=%0d", mute, vu_enable);
    vc0 = vc_cnt;
    enc_switch = 1'b0;
    idle(60);
    check("release_mute", mute, 1'b0);
    check("release_vol_changed", vc_cnt - vc0, 0);
    $display("switch release: mute=%0d", mute);

    // Host and encoder in the same cycle: host first, then the step.
    idle(200);
    rd0 = rd_cnt;
    host_wr_stb = 1'b1;
    host_wr_data = 8'd10;
    enc_state_change = 1'b1;
    clkwise = 1'b1;
    @(negedge clk);
    host_wr_stb = 1'b0;
    enc_state_change = 1'b0;
    wait_ack(lat);
    check("arb_ack_latency", lat, 4);
    idle(20);
    check("arb_volume", volume, 8'd11);
    check("arb_rd_stb", rd_cnt - rd0, 1);
    $display("arbitration: volume=%0d", volume);

    // Second event while the first is still pending is dropped.
    idle(200);
    rd0 = rd_cnt;
    enc_pulse(1'b1);
    enc_pulse(1'b1);
    idle(30);
    check("drop_volume", volume, 8'd12);
    check("drop_rd_stb", rd_cnt - rd0, 1);
    $display("pending drop: volume=%0d", volume);

    // Reset while the FSM sits in STEP.
    idle(200);
    rd0 = rd_cnt;
    enc_pulse(1'b1);
    @(posedge clk);
    #1;
    check("abort_in_step", status[3:2], 2'd2);
    reset = 1'b0;
    #1;
    check("abort_volume", volume, 8'd0);
    check("abort_mute", mute, 1'b1);
    idle(3);
    reset = 1'b1;
    idle(20);
    check("abort_rd_stb", rd_cnt - rd0, 0);
    check("abort_status", status, 8'h10);
    check("abort_volume_after", volume, 8'd0);
    $display("reset abort: volume=%0d mute=%0d", volume, mute);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
